// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream into 32-bit big-endian words (first byte lands in bits 31:24).
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         byte_en,
  input  logic [BYTE_W-1:0]            byte_data,
  output logic                         word_valid,
  output logic [WORD_BYTES*BYTE_W-1:0] word
);

  // Only the three older bytes need storage; the fourth is taken straight from the input.
  logic [(WORD_BYTES-1)*BYTE_W-1:0] shreg;
  logic [1:0]                       cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (byte_en) begin
      shreg <= {shreg[(WORD_BYTES-2)*BYTE_W-1:0], byte_data};
      cnt   <= cnt + 2'd1;
    end
  end

  assign word_valid = byte_en && (cnt == 2'd3);
  assign word       = {shreg, byte_data};

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into instruction memory and holds the core in reset
// until it completes. Optional trailing XOR checksum: define IMEM_LOADER_CHKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  state_t              state, state_nxt;
  logic                xfer;
  logic                len_ok;
  logic                last_word;
  logic                word_valid;
  logic [31:0]         word;
  logic [ADDR_W-1:0]   len;
  logic [ADDR_W-1:0]   word_addr;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [BYTE_W-1:0]   csum;
`endif

  assign xfer      = byte_valid && byte_ready;
  assign len_ok    = (byte_data >> ADDR_W) == '0;
  assign last_word = word_valid && (word_addr == len);

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (xfer && (state == S_LEN)),
    .byte_en    (xfer && (state == S_DATA)),
    .byte_data  (byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LEN;
      S_LEN:  if (xfer) state_nxt = len_ok ? S_DATA : S_ERR;
`ifdef IMEM_LOADER_CHKSUM_EN
      S_DATA: if (last_word) state_nxt = S_CHK;
      S_CHK:  if (xfer) state_nxt = (byte_data == csum) ? S_DONE : S_ERR;
`else
      S_DATA: if (last_word) state_nxt = S_DONE;
      S_CHK:  state_nxt = S_IDLE;
`endif
      S_DONE: if (start) state_nxt = S_LEN;
      S_ERR:  if (start) state_nxt = S_LEN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      core_hold  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      len        <= '0;
      word_addr  <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_nxt;
      byte_ready <= (state_nxt == S_LEN) || (state_nxt == S_DATA) || (state_nxt == S_CHK);
      core_hold  <= (state_nxt != S_DONE);
      done       <= (state_nxt == S_DONE);
      err        <= (state_nxt == S_ERR);
      wr_en      <= word_valid;
      if (word_valid) begin
        wr_addr   <= word_addr;
        wr_data   <= word;
        word_addr <= word_addr + ADDR_W'(1);
      end
      if (xfer && (state == S_LEN)) begin
        len       <= byte_data[ADDR_W-1:0];
        word_addr <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
        csum      <= '0;
`endif
      end
`ifdef IMEM_LOADER_CHKSUM_EN
      if (xfer && (state == S_DATA)) csum <= csum ^ byte_data;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader; follows IMEM_LOADER_CHKSUM_EN for the stream format.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst, start, byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready, wr_en, core_hold, done, err;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_hold  (core_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] exp_e;
  logic [31:0]        img[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no write", wr_addr, wr_data);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(exp_e[ADDR_W+31:32]));
        check("wr_data", wr_data, exp_e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_timeout: got byte_ready 0 expected 1 for byte 0x%0h", b);
      byte_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic idle_valid();
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load(input int nw, input int maxgap, input bit expect_ok);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    send_byte(8'(nw - 1), 0);
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = img[w][31-8*k -: 8];
        x = x ^ b;
        if (k == 3) exp_q.push_back({ADDR_W'(w), img[w]});
        send_byte(b, int'($urandom_range(0, maxgap)));
      end
    end
`ifdef IMEM_LOADER_CHKSUM_EN
    send_byte(expect_ok ? x : (x ^ 8'h01), 0);
`endif
    #1;
    check("end_done", 32'(done), 32'(expect_ok));
    check("end_err", 32'(err), 32'(!expect_ok));
    check("end_core_hold", 32'(core_hold), 32'(!expect_ok));
    idle_valid();
    @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int wr0;
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_core_hold", 32'(core_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single word: 00,12,34,56,78 (+ checksum 08)
    img[0] = 32'h12345678;
    pulse_start();
    load(1, 0, 1'b1);

    // Full 32-word image with gaps; restart from DONE
    for (int w = 0; w < 32; w++)
      img[w] = {8'(w), 8'(w * 3 + 1), 8'hA5, ~8'(w)};
    pulse_start();
    check("restart_done_drop", 32'(done), 32'd0);
    check("restart_core_hold", 32'(core_hold), 32'd1);
    wr0 = n_wr;
    load(32, 2, 1'b1);
    check("full_wr_count", 32'(n_wr - wr0), 32'd32);

    // Out-of-range length
    wr0 = n_wr;
    pulse_start();
    send_byte(8'h20, 0);
    #1;
    check("len_err", 32'(err), 32'd1);
    check("len_core_hold", 32'(core_hold), 32'd1);
    check("len_done", 32'(done), 32'd0);
    idle_valid();
    check("len_byte_ready", 32'(byte_ready), 32'd0);
    check("len_no_write", 32'(n_wr - wr0), 32'd0);
    img[0] = 32'hCAFEF00D;
    pulse_start();
    load(1, 1, 1'b1);

`ifdef IMEM_LOADER_CHKSUM_EN
    // Bad checksum: 12,34,56,78 then 09
    img[0] = 32'h12345678;
    wr0 = n_wr;
    pulse_start();
    load(1, 0, 1'b0);
    check("chk_wr_count", 32'(n_wr - wr0), 32'd1);
`endif

    // Reset mid-load after 6 data bytes, start pulses in DATA ignored
    wr0 = n_wr;
    pulse_start();
    exp_q.push_back({ADDR_W'(0), 32'hA1B2C3D4});
    send_byte(8'h01, 0);
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 0);
    send_byte(8'hC3, 0);
    send_byte(8'hD4, 0);
    send_byte(8'h11, 0);
    idle_valid();
    pulse_start();
    check("data_start_ignored", 32'(byte_ready), 32'd1);
    send_byte(8'h22, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_byte_ready", 32'(byte_ready), 32'd0);
    check("mid_rst_core_hold", 32'(core_hold), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_rst_still_idle", 32'(byte_ready), 32'd0);
    check("mid_rst_wr_count", 32'(n_wr - wr0), 32'd1);
    check("mid_rst_sb_drained", 32'(exp_q.size()), 32'd0);
    byte_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
